// File: rtl/adder_pkg.sv
// Shared KPG carry-resolution types and helpers for the prefix adder datapath.
// Encoding: KILL=00, PROP=01, GEN=11, so bit1 is the generate term and bit0 the any-one term.
package adder_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_KILL = 2'b00;
  localparam kpg_t KPG_PROP = 2'b01;
  localparam kpg_t KPG_GEN  = 2'b11;

  // The upper span decides unless it only propagates, in which case the lower span shows through.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_PROP) ? lo : hi;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/kpg_prefix_level.sv
// One Kogge-Stone level: entry i merges with entry i-DIST; pure combinational, no handshake.
// Entries below DIST already hold their final span for this level and pass straight through.
module kpg_prefix_level
  import adder_pkg::*;
#(
  parameter int N    = 25,
  parameter int DIST = 1
) (
  input  kpg_t [N-1:0] src,
  output kpg_t [N-1:0] res
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    if (i < DIST) begin : g_pass
      assign res[i] = src[i];
    end else begin : g_comb
      assign res[i] = kpg_combine(src[i], src[i-DIST]);
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/sub; latency ceil(LEVELS/LPS)+1 cycles, one beat per cycle.
// All stages advance together only when the output slot is empty or being drained.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int LPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N      = WIDTH + 1;
  localparam int LEVELS = clog2(N);
  localparam int NSTG   = (LEVELS + LPS - 1) / LPS;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             vld   [0:NSTG];
  logic [TAG_W-1:0] tag_s [0:NSTG];
  logic [WIDTH-1:0] p_s   [1:NSTG];
  kpg_t [N-1:0]     kq    [1:NSTG];

  logic [WIDTH-1:0] bx, p0;
  kpg_t [N-1:0]     kpg0;

  assign bx = b_q ^ {WIDTH{sub_q}};
  assign p0 = a_q ^ bx;

  // Entry 0 is the carry-in; subtraction injects the +1 of the two's complement here.
  always_comb begin
    kpg0    = '0;
    kpg0[0] = sub_q ? KPG_GEN : KPG_KILL;
    for (int i = 0; i < WIDTH; i++) begin
      kpg0[i+1] = {a_q[i] & bx[i], a_q[i] | bx[i]};
    end
  end

  kpg_t [N-1:0] lvl_i [1:LEVELS];
  kpg_t [N-1:0] lvl_o [1:LEVELS];
  kpg_t [N-1:0] stg_d [1:NSTG];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    if ((k - 1) % LPS != 0) begin : g_chain
      assign lvl_i[k] = lvl_o[k-1];
    end else if (k == 1) begin : g_first
      assign lvl_i[k] = kpg0;
    end else begin : g_reg
      assign lvl_i[k] = kq[(k-1)/LPS];
    end
    kpg_prefix_level #(.N(N), .DIST(1 << (k - 1))) u_lvl (
      .src (lvl_i[k]),
      .res (lvl_o[k])
    );
  end

  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    localparam int LAST = (s * LPS < LEVELS) ? s * LPS : LEVELS;
    assign stg_d[s] = lvl_o[LAST];
  end

  logic [N-1:0] carry;
  logic [WIDTH:0] sum_d;
  logic           ovf_d;

  always_comb begin
    carry = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      carry[i] = (kq[NSTG][i] == KPG_GEN);
    end
  end

  assign sum_d = {carry[WIDTH], p_s[NSTG] ^ carry[WIDTH-1:0]};
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  // Data registers only load under a valid beat so bubbles leave the last result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      out_tag   <= '0;
      for (int s = 0; s <= NSTG; s++) begin
        vld[s]   <= 1'b0;
        tag_s[s] <= '0;
      end
      for (int s = 1; s <= NSTG; s++) begin
        p_s[s] <= '0;
        kq[s]  <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        a_q      <= a;
        b_q      <= b;
        sub_q    <= sub;
        tag_s[0] <= in_tag;
      end
      vld[1] <= vld[0];
      if (vld[0]) begin
        kq[1]    <= stg_d[1];
        p_s[1]   <= p0;
        tag_s[1] <= tag_s[0];
      end
      for (int s = 2; s <= NSTG; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1]) begin
          kq[s]    <= stg_d[s];
          p_s[s]   <= p_s[s-1];
          tag_s[s] <= tag_s[s-1];
        end
      end
      out_valid <= vld[NSTG];
      if (vld[NSTG]) begin
        sum     <= sum_d;
        ovf     <= ovf_d;
        out_tag <= tag_s[NSTG];
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench: directed checks on the default build plus randomized sweeps over three parameter sets.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [4];

  typedef struct {
    longint unsigned sm;
    bit              ov;
    int              tg;
  } exp_t;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as range violation.
  function automatic void ref_op(input int w, input longint unsigned av, input longint unsigned bv,
                                 input bit s, output longint unsigned sm, output bit ov);
    longint half, sa, sb, r;
    half = longint'(1) << (w - 1);
    sa = longint'(av);
    sb = longint'(bv);
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    r  = s ? sa - sb : sa + sb;
    ov = (r >= half) || (r < -half);
    sm = s ? av + (longint'(1) << w) - bv : av + bv;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W   = (g == 0) ? 24 : (g == 1) ? 8 : (g == 2) ? 32 : 24;
    localparam int L   = (g == 0) ? 1  : (g == 1) ? 2 : (g == 2) ? 3  : 5;
    localparam int LAT = (g == 0) ? 6  : (g == 1) ? 3 : (g == 2) ? 3  : 2;
    localparam int TW  = (g == 0) ? 4  : 8;

    logic          rst, in_valid, in_ready, sub, out_valid, out_ready, ovf;
    logic [W-1:0]  a, b;
    logic [TW-1:0] in_tag, out_tag;
    logic [W:0]    sum;
    exp_t          q[$];
    int            seen[$];

    prefix_adder_pipe #(.WIDTH(W), .LPS(L), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .ovf       (ovf),
      .out_tag   (out_tag)
    );

    initial begin : mon
      exp_t            e;
      longint unsigned esm;
      bit              eov;
      bit              stall;
      logic [W:0]      psum;
      logic            pov;
      logic [TW-1:0]   ptag;
      stall = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        check($sformatf("cfg%0d in_ready", g), in_ready, !rst && (!out_valid || out_ready));
        if (stall) begin
          check($sformatf("cfg%0d hold_valid", g), out_valid, 1);
          check($sformatf("cfg%0d hold_sum", g), sum, psum);
          check($sformatf("cfg%0d hold_ovf", g), ovf, pov);
          check($sformatf("cfg%0d hold_tag", g), out_tag, ptag);
        end
        stall = out_valid && !out_ready && !rst;
        psum  = sum;
        pov   = ovf;
        ptag  = out_tag;
        if (rst) begin
          q.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL cfg%0d unexpected_out: tag %0h appeared, expected no result", g, out_tag);
            end else begin
              e = q.pop_front();
              check($sformatf("cfg%0d sum", g), sum, e.sm);
              check($sformatf("cfg%0d ovf", g), ovf, e.ov);
              check($sformatf("cfg%0d tag", g), out_tag, e.tg);
            end
            seen.push_back(int'(out_tag));
          end
          if (in_valid && in_ready) begin
            ref_op(W, a, b, sub, esm, eov);
            e.sm = esm;
            e.ov = eov;
            e.tg = int'(in_tag);
            q.push_back(e);
          end
        end
      end
    end

    if (g == 0) begin : dir
      task automatic idle();
        in_valid = 1'b0;
        a        = W'($urandom());
        b        = W'($urandom());
        sub      = 1'($urandom_range(0, 1));
        in_tag   = TW'($urandom());
      endtask

      task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input logic [TW-1:0] tv);
        int n;
        in_valid = 1'b1;
        a = av; b = bv; sub = sv; in_tag = tv;
        n = 0;
        #1;
        while (!in_ready && n < 100) begin
          @(negedge clk);
          #1;
          n++;
        end
        if (!in_ready) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 100 cycles");
        end
        @(negedge clk);
      endtask

      task automatic run1(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input logic [TW-1:0] tv, input logic [W:0] esum, input logic eovf);
        int c;
        send(av, bv, sv, tv);
        idle();
        c = 0;
        #1;
        while (!out_valid && c < 40) begin
          @(negedge clk);
          #1;
          c++;
        end
        check("dir latency", c, LAT);
        check("dir sum", sum, esum);
        check("dir ovf", ovf, eovf);
        check("dir tag", out_tag, tv);
        @(negedge clk);
      endtask

      initial begin
        longint unsigned msm;
        bit              mov;
        int              c;
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        ref_op(24, 64'hFFFFFF, 1, 1'b0, msm, mov);
        check("model wrap", msm, 64'h1000000);
        ref_op(24, 64'h800000, 1, 1'b1, msm, mov);
        check("model sub sum", msm, 64'h17FFFFF);
        check("model sub ovf", mov, 1);
        @(negedge clk);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst sum", sum, 0);
        check("rst ovf", ovf, 0);
        check("rst tag", out_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", in_ready, 1);
        @(negedge clk);

        run1(24'hFFFFFF, 24'h000001, 1'b0, 4'd1, 25'h1000000, 1'b0);
        run1(24'h000005, 24'h000007, 1'b1, 4'd2, 25'h0FFFFFE, 1'b0);
        run1(24'h000007, 24'h000005, 1'b1, 4'd3, 25'h1000002, 1'b0);
        run1(24'h7FFFFF, 24'h000001, 1'b0, 4'd4, 25'h0800000, 1'b1);
        run1(24'h800000, 24'h000001, 1'b1, 4'd5, 25'h17FFFFF, 1'b1);

        seen.delete();
        fork
          begin : drv
            for (int i = 0; i < 10; i++) begin
              send(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)), TW'(i));
            end
            idle();
          end
          begin : ctl
            int k;
            k = 0;
            #1;
            while (!out_valid && k < 40) begin
              @(negedge clk);
              #1;
              k++;
            end
            @(negedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            repeat (3) begin
              #1;
              check("stall in_ready", in_ready, 0);
              check("stall out_valid", out_valid, 1);
              @(negedge clk);
            end
            out_ready = 1'b1;
          end
        join
        c = 0;
        while (seen.size() < 10 && c < 60) begin
          @(negedge clk);
          c++;
        end
        repeat (10) @(negedge clk);
        check("stream count", seen.size(), 10);
        for (int i = 0; i < seen.size(); i++) check("stream order", seen[i], i);

        for (int i = 0; i < 4; i++) send(W'($urandom()), W'($urandom()), 1'b0, TW'(10 + i));
        idle();
        rst = 1'b1;
        seen.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst in_ready", in_ready, 1);
        @(negedge clk);
        run1(24'h123456, 24'h654321, 1'b0, 4'd14, 25'h0777777, 1'b0);
        repeat (20) @(negedge clk);
        check("midrst out count", seen.size(), 1);
        if (seen.size() > 0) check("midrst out tag", seen[0], 14);
        done[g] = 1'b1;
      end
    end else begin : rnd
      initial begin
        int sent, cyc, c;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; in_tag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        a = W'($urandom());
        b = W'($urandom());
        sub = 1'($urandom_range(0, 1));
        in_tag = '1;
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        #1;
        while (!out_valid && c < 40) begin
          @(negedge clk);
          #1;
          c++;
        end
        check($sformatf("cfg%0d latency", g), c, LAT);
        @(negedge clk);

        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 40000) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          a         = W'({$urandom(), $urandom()});
          b         = W'({$urandom(), $urandom()});
          if ($urandom_range(0, 15) == 0) a = '1;
          if ($urandom_range(0, 15) == 0) b = W'(1);
          sub       = 1'($urandom_range(0, 1));
          in_tag    = TW'(sent);
          out_ready = ($urandom_range(0, 9) < 7);
          #1;
          if (in_valid && in_ready) sent++;
          @(negedge clk);
          cyc++;
        end
        check($sformatf("cfg%0d sent", g), sent, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (q.size() != 0 && c < 100) begin
          @(negedge clk);
          c++;
        end
        #2;
        check($sformatf("cfg%0d drain", g), q.size(), 0);
        done[g] = 1'b1;
      end
    end
  end

  initial begin
    int c;
    c = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && c < 80000) begin
      @(negedge clk);
      c++;
    end
    if (!(done[0] && done[1] && done[2] && done[3])) begin
      checks++;
      errors++;
      $display("FAIL timeout: tests incomplete after %0d cycles, required completion", c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter LPS, default 1: prefix levels per pipeline stage, legal range 1..LEVELS.
REQ-003 SHALL have parameter TAG_W, default 4: sideband tag width, legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: operand beat present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts beat this cycle.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 SHALL have port sub, input, 1 bit: 0 computes a+b, 1 computes a-b.
REQ-010 SHALL have port in_tag, input, TAG_W bits: opaque ID carried alongside the operands.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH+1 bits: result; sum[WIDTH] is the carry-out (add) or the not-borrow (sub).
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have port out_tag, output, TAG_W bits: tag of the result.

Function
REQ-016 SHALL encode each bit position as a KPG pair: KILL=2'b00, PROP=2'b01, GEN=2'b11.
REQ-017 SHALL form WIDTH+1 KPG entries: entry 0 is carry-in (GEN if sub=1, else KILL); entry i+1 comes from a[i] and b'[i], where b'=b XOR {WIDTH{sub}}.
REQ-018 SHALL resolve carries with a Kogge-Stone prefix over LEVELS=clog2(WIDTH+1) levels, where level k combines entry i with entry i-2^(k-1).
REQ-019 SHALL use the combine rule: the upper entry wins unless it is PROP, in which case the lower entry passes through.
REQ-020 SHALL compute sum[i] = a[i] XOR b'[i] XOR carry[i], where carry[i] = (resolved entry i == GEN).
REQ-021 SHALL set sum[WIDTH] = carry[WIDTH].
REQ-022 SHALL set ovf = carry[WIDTH] XOR carry[WIDTH-1].
REQ-023 SHALL register operands, sub and tag at input acceptance.
REQ-024 SHALL register the KPG vector after every LPS prefix levels (the last group may be partial).
REQ-025 SHALL register the sum, ovf and tag into the output slot.
REQ-026 SHALL have latency LAT = ceil(LEVELS/LPS)+1 cycles: a beat accepted at edge N is presented with out_valid=1 after edge N+LAT, provided no stall occurs.
REQ-027 SHALL advance all stages together on enable en = !out_valid || out_ready.
REQ-028 SHALL drive in_ready = en && !rst.
REQ-029 SHALL hold every stage register, including its valid bit, unchanged while en=0; bubbles also hold.
REQ-030 SHALL keep sum, ovf and out_tag stable while out_valid=1 and out_ready=0.
REQ-031 SHALL perform simultaneous acceptance and output drain in the same cycle with no loss or duplication.
REQ-032 SHALL deliver results in acceptance order.
REQ-033 SHALL sustain a throughput of 1 beat/cycle when out_ready is held at 1.
REQ-034 SHALL ignore a, b, sub and in_tag when in_valid=0; a bubble SHALL propagate as valid=0.
REQ-035 SHALL compute full carry wrap-around: all-ones + 1 yields sum[WIDTH]=1 with the low bits zero.

Reset
REQ-036 SHALL, when rst=1 at a clock edge, clear every stage valid bit and out_valid to 0, and all data registers, sum, ovf and out_tag to 0.
REQ-037 SHALL discard in-flight beats when reset is asserted mid-operation; none SHALL appear after reset.
REQ-038 SHALL hold in_ready at 0 while rst=1, and SHALL allow acceptance to resume on the first edge after rst falls.

Structure
REQ-039 SHALL use shared package adder_pkg containing: kpg_t (2-bit typedef), constants KPG_KILL, KPG_PROP and KPG_GEN, function kpg_combine, and function clog2.
REQ-040 SHALL implement one sub-module, kpg_prefix_level: one prefix level with parameters N and DIST, containing pure combine cells, with entries below DIST passed through unchanged.
REQ-041 SHALL generate instances of kpg_prefix_level; the top level owns all registers and handshake logic.

Verification
REQ-042 SHALL cover: WIDTH=24, LPS=1, a=24'hFFFFFF, b=1, sub=0 -> sum=25'h1000000, ovf=0, out_valid exactly 6 cycles after acceptance.
REQ-043 SHALL cover: a=5, b=7, sub=1 -> sum=25'h0FFFFFE (sum[24]=0, borrow), ovf=0; and a=7, b=5, sub=1 -> sum=25'h1000002.
REQ-044 SHALL cover: a=24'h7FFFFF, b=1, sub=0 -> sum=25'h0800000, ovf=1; and a=24'h800000, b=1, sub=1 -> ovf=1.
REQ-045 SHALL cover: 10 back-to-back beats with tags 0..9 and out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, tags 0..9 emerge once each and in order.
REQ-046 SHALL cover: 4 beats in flight, then rst high for 1 cycle -> out_valid=0 after that edge, none of the 4 tags ever output, next accepted beat output after LAT cycles.
REQ-047 SHALL cover: parameter sweep (WIDTH,LPS) = (8,2), (32,3), (24,5) with 10k random beats and random out_ready -> every result equals the reference a±b and ovf, with LAT = 3, 3 and 2 cycles respectively.
